prv_csr_arbiter: RTL and testbench
==================================

Name: prv_csr_arbiter

Overview:
- Parametrised successor to the single-port pipeline-to-priv CSR path.
- Arbitrates CSR read/modify/write requests from NUM_PORTS pipeline-side requesters (lanes, debug module, RISC-MGMT) onto the single priv_block CSR port.
- Uses a valid/ready request handshake, an ack-based priv handshake, a per-port response channel, round-robin fairness, flush handling and a response timeout.
- Sits between the pipeline/hazard units and the priv block.

Parameters:
- NUM_PORTS, 2, number of requesters; minimum 1.
- WORD_W, 32, CSR data width.
- CSR_ADDR_W, 12, CSR address width.
- TIMEOUT, 16, max cycles waiting for priv ack before error response; 0 disables the timeout.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accepted this cycle.
- req_op  in  NUM_PORTS*2  per-port op: 0 swap, 1 set, 2 clr, 3 read_only.
- req_addr  in  NUM_PORTS*CSR_ADDR_W  per-port CSR address.
- req_wdata  in  NUM_PORTS*WORD_W  per-port write data.
- resp_valid  out  NUM_PORTS  one-cycle response pulse to the owning port.
- resp_rdata  out  WORD_W  response read data, shared by all ports.
- resp_err  out  1  response is invalid_priv_isn or timeout.
- pipe_clear  in  1  flush.
- priv_req  out  1  request to priv block.
- priv_swap, priv_set, priv_clr, priv_read_only  out  1 each  one-hot decode of op.
- priv_addr  out  CSR_ADDR_W  CSR address to priv block.
- priv_wdata  out  WORD_W  write data to priv block.
- priv_ack  in  1  priv completion, may arrive the same cycle as priv_req or later.
- priv_rdata  in  WORD_W  priv read data, valid with priv_ack.
- priv_invalid  in  1  invalid_priv_isn, valid with priv_ack.

Behaviour:
- **Reset:** all outputs are 0. State is IDLE, the round-robin pointer is 0, timer is 0, held request and owner are 0.
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE:**
  - If pipe_clear=0 and any req_valid, grant the first valid port at or after the rr pointer, wrapping modulo NUM_PORTS.
  - Assert req_ready for the granted port only, same cycle (combinational).
  - Latch op, addr, wdata and owner; go to ISSUE.
  - If pipe_clear=1, no grant and req_ready is all 0.
- **ISSUE:**
  - priv_req=1 and priv_* are driven from registers, stable until ack.
  - On priv_ack: latch rdata, err=priv_invalid, drop=drop|pipe_clear; go to RESP.
  - Timer increments each ISSUE cycle. When timer==TIMEOUT-1 with no ack: err=1, rdata=0; go to RESP, and priv_req drops the next cycle.
  - pipe_clear in ISSUE does not abort: CSR side effects are atomic. It sets drop.
  - req_ready is all 0.
- **RESP (exactly one cycle):**
  - resp_valid[owner]=1 unless drop=1.
  - resp_rdata and resp_err are held valid this cycle.
  - rr pointer becomes owner+1, wrapping modulo NUM_PORTS.
  - Clear drop and timer; go to IDLE.
- **Latency:** grant to resp_valid is 2 cycles with a same-cycle ack; 1+N+1 cycles with ack N cycles after the first priv_req cycle.
- **Throughput:** at most one transaction per 3 cycles. There are no back-to-back grants because RESP always precedes IDLE.
- **Requester rules:** a requester must hold valid, op, addr and wdata stable until req_ready. Deasserting valid before ready is legal; the request is simply not granted.
- **Spurious ack:** priv_ack outside ISSUE is ignored.
- **RST mid-transaction:** return to IDLE immediately, no response, rr pointer resets to 0.
- **NUM_PORTS=1:** the rr pointer is a constant 0, with identical behaviour otherwise.
- **Op decode:** exactly one of priv_swap/set/clr/read_only is 1 while priv_req=1, all 0 otherwise.

Decomposition:
- **Shared package prv_csr_arb_pkg:**
  - csr_op_t enum (SWAP, SET, CLR, RO, 2 bits);
  - arb_state_t enum (IDLE, ISSUE, RESP);
  - csr_req_t struct (op, addr, wdata).
- **Sub-module rr_arbiter:**
  - parameter N;
  - inputs req[N], ptr[$clog2(N)];
  - outputs gnt one-hot and gnt_idx;
  - purely combinational.
  - It is reused later for TLB-miss arbitration.

Test Plan:
- **Single request, same-cycle ack:** port0 set, addr 0x300, wdata 0x8. Expect req_ready[0] at cycle 0, priv_set=1 and priv_addr=0x300 at cycle 1; ack with rdata 0x1800 gives resp_valid=01 and rdata 0x1800 at cycle 2.
- **Fairness:** ports 0 and 1 request continuously. Grants alternate 0,1,0,1 over 4 transactions, one grant every 3 cycles.
- **Delayed ack:** ack 5 cycles after priv_req. priv_req is held 6 cycles with addr and wdata stable; resp_valid at grant+7.
- **Timeout:** TIMEOUT=4, no ack. resp_err=1 and rdata=0 after 4 ISSUE cycles; a later stray priv_ack is ignored.
- **Flush:**
  - pipe_clear during ISSUE: the request completes at priv, resp_valid stays 0.
  - pipe_clear in IDLE with req_valid=11: req_ready=00.
- **Invalid priv:** priv_invalid=1 with ack, read_only addr 0xF14. resp_err=1 and resp_valid pulses to the owner. Also assert RST in ISSUE: outputs are 0 the next cycle and no response is issued.

Source files
------------

// File: rtl/prv_csr_arb_pkg.sv
// Shared types for the CSR request arbiter: op encoding, FSM states and the
// default-width request record.
package prv_csr_arb_pkg;

    localparam int unsigned CsrAddrW = 12;
    localparam int unsigned WordW    = 32;

    typedef enum logic [1:0] {
        OpSwap = 2'd0,
        OpSet  = 2'd1,
        OpClr  = 2'd2,
        OpRo   = 2'd3
    } csr_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } arb_state_t;

    typedef struct packed {
        csr_op_t               op;
        logic [CsrAddrW-1:0]   addr;
        logic [WordW-1:0]      wdata;
    } csr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/prv_csr_arbiter.sv
// Arbitrates CSR requests from several pipeline-side ports onto the single priv
// CSR port, with round-robin fairness, flush-drop and an ack timeout.
module prv_csr_arbiter
    import prv_csr_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned CSR_ADDR_W = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*2-1:0]          req_op,
    input  logic [NUM_PORTS*CSR_ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*WORD_W-1:0]     req_wdata,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [WORD_W-1:0]               resp_rdata,
    output logic                            resp_err,
    input  logic                            pipe_clear,
    output logic                            priv_req,
    output logic                            priv_swap,
    output logic                            priv_set,
    output logic                            priv_clr,
    output logic                            priv_read_only,
    output logic [CSR_ADDR_W-1:0]           priv_addr,
    output logic [WORD_W-1:0]               priv_wdata,
    input  logic                            priv_ack,
    input  logic [WORD_W-1:0]               priv_rdata,
    input  logic                            priv_invalid
);

    localparam int unsigned IdxW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IdxW-1:0]   LastPort  = IdxW'(NUM_PORTS - 1);

    // Same layout as csr_req_t, sized by this instance's parameters.
    typedef struct packed {
        csr_op_t               op;
        logic [CSR_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     wdata;
    } held_req_t;

    arb_state_t          state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    held_req_t           held_q, held_d;
    logic                drop_q, drop_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [NUM_PORTS-1:0] gnt;
    logic [IdxW-1:0]      gnt_idx;
    held_req_t            sel_req;

    rr_arbiter #(
        .N(NUM_PORTS)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        sel_req = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_req.op    = csr_op_t'(req_op[2*p +: 2]);
                sel_req.addr  = req_addr[CSR_ADDR_W*p +: CSR_ADDR_W];
                sel_req.wdata = req_wdata[WORD_W*p +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        timer_d  = timer_q;
        held_d   = held_q;
        drop_d   = drop_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (!pipe_clear && |req_valid) begin
                    held_d  = sel_req;
                    owner_d = gnt_idx;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                timer_d = timer_q + 1'b1;
                // A flush cannot abort the priv access, only suppress its response.
                drop_d  = drop_q | pipe_clear;
                if (priv_ack) begin
                    rdata_d = priv_rdata;
                    err_d   = priv_invalid;
                    state_d = StResp;
                end else if (TIMEOUT != 0 && timer_q == TimerLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = (owner_q == LastPort) ? '0 : owner_q + 1'b1;
                drop_d   = 1'b0;
                timer_d  = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready      = (state_q == StIdle && !pipe_clear) ? gnt : '0;
        priv_req       = (state_q == StIssue);
        priv_swap      = 1'b0;
        priv_set       = 1'b0;
        priv_clr       = 1'b0;
        priv_read_only = 1'b0;
        if (priv_req) begin
            unique case (held_q.op)
                OpSwap: priv_swap      = 1'b1;
                OpSet:  priv_set       = 1'b1;
                OpClr:  priv_clr       = 1'b1;
                OpRo:   priv_read_only = 1'b1;
                default: ;
            endcase
        end
        priv_addr  = held_q.addr;
        priv_wdata = held_q.wdata;
        resp_valid = '0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (state_q == StResp) begin
            if (!drop_q) begin
                resp_valid[owner_q] = 1'b1;
            end
            resp_rdata = rdata_q;
            resp_err   = err_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            timer_q  <= '0;
            held_q   <= '0;
            drop_q   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            timer_q  <= timer_d;
            held_q   <= held_d;
            drop_q   <= drop_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_prv_csr_arbiter.sv
// Randomised bench for prv_csr_arbiter against a transaction-level model of
// grant order, priv access length, drop and timeout rules.
module tb_prv_csr_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned TO = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_ready;
    logic [NP*2-1:0]  req_op = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*W-1:0]  req_wdata = '0;
    logic [NP-1:0]    resp_valid;
    logic [W-1:0]     resp_rdata;
    logic             resp_err;
    logic             pipe_clear = 1'b0;
    logic             priv_req;
    logic             priv_swap, priv_set, priv_clr, priv_read_only;
    logic [AW-1:0]    priv_addr;
    logic [W-1:0]     priv_wdata;
    logic             priv_ack = 1'b0;
    logic [W-1:0]     priv_rdata = '0;
    logic             priv_invalid = 1'b0;

    prv_csr_arbiter #(
        .NUM_PORTS (NP),
        .WORD_W    (W),
        .CSR_ADDR_W(AW),
        .TIMEOUT   (TO)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .pipe_clear    (pipe_clear),
        .priv_req      (priv_req),
        .priv_swap     (priv_swap),
        .priv_set      (priv_set),
        .priv_clr      (priv_clr),
        .priv_read_only(priv_read_only),
        .priv_addr     (priv_addr),
        .priv_wdata    (priv_wdata),
        .priv_ack      (priv_ack),
        .priv_rdata    (priv_rdata),
        .priv_invalid  (priv_invalid)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int rr       = 0;

    logic [1:0]    tx_op    [NP];
    logic [AW-1:0] tx_addr  [NP];
    logic [W-1:0]  tx_wdata [NP];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_reqs();
        for (int p = 0; p < int'(NP); p++) begin
            tx_op[p]    = 2'($urandom);
            tx_addr[p]  = AW'($urandom);
            tx_wdata[p] = $urandom;
        end
    endtask

    task automatic drive_reqs();
        for (int p = 0; p < int'(NP); p++) begin
            req_op[2*p +: 2]     = tx_op[p];
            req_addr[AW*p +: AW] = tx_addr[p];
            req_wdata[W*p +: W]  = tx_wdata[p];
        end
    endtask

    // First requester at or after the round-robin position, wrapping.
    function automatic int pick(input logic [NP-1:0] mask);
        for (int i = 0; i < int'(NP); i++) begin
            int p;
            p = (rr + i) % int'(NP);
            if (mask[p]) return p;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, "_priv_req"}, 64'(priv_req), 64'd0);
        check_eq({tag, "_priv_ops"},
                 64'({priv_swap, priv_set, priv_clr, priv_read_only}), 64'd0);
        check_eq({tag, "_priv_addr"}, 64'(priv_addr), 64'd0);
        check_eq({tag, "_priv_wdata"}, 64'(priv_wdata), 64'd0);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
        check_eq({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    endtask

    // One arbitration round starting in an idle cycle. Ack arrives `delay` cycles
    // after the first priv_req cycle; delay >= TO means no ack (timeout).
    task automatic txn(input logic [NP-1:0] mask, input bit flush_idle, input int delay,
                       input bit inv, input int clear_at, input int rst_at,
                       input logic [W-1:0] rdata);
        int            g;
        int            len;
        bit            timed_out;
        bit            dropped;
        logic [NP-1:0] exp_ready;
        logic [NP-1:0] exp_resp;
        logic [3:0]    base;
        logic [3:0]    exp_ops;
        base = 4'b1000;

        drive_reqs();
        req_valid    = mask;
        pipe_clear   = flush_idle;
        priv_ack     = 1'($urandom);
        priv_invalid = 1'($urandom);
        priv_rdata   = $urandom;
        #1;
        g = flush_idle ? -1 : pick(mask);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("idle_req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("idle_priv_req", 64'(priv_req), 64'd0);
        check_eq("idle_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge CLK);
        #1;
        if (g < 0) return;

        timed_out = (delay >= int'(TO));
        len       = timed_out ? int'(TO) : delay + 1;
        dropped   = 1'b0;
        exp_ops   = base >> tx_op[g];
        for (int k = 0; k < len; k++) begin
            req_valid    = NP'($urandom);
            pipe_clear   = (k == clear_at);
            priv_ack     = (k == delay);
            priv_invalid = inv;
            priv_rdata   = (k == delay) ? rdata : $urandom;
            RST          = (k == rst_at);
            #1;
            check_eq("issue_priv_req", 64'(priv_req), 64'd1);
            check_eq("issue_priv_ops",
                     64'({priv_swap, priv_set, priv_clr, priv_read_only}), 64'(exp_ops));
            check_eq("issue_priv_addr", 64'(priv_addr), 64'(tx_addr[g]));
            check_eq("issue_priv_wdata", 64'(priv_wdata), 64'(tx_wdata[g]));
            check_eq("issue_req_ready", 64'(req_ready), 64'd0);
            check_eq("issue_resp_valid", 64'(resp_valid), 64'd0);
            if (k == clear_at) dropped = 1'b1;
            @(posedge CLK);
            #1;
            if (k == rst_at) begin
                RST        = 1'b0;
                req_valid  = '0;
                pipe_clear = 1'b0;
                priv_ack   = 1'b0;
                rr         = 0;
                #1;
                check_all_zero("rst_mid");
                return;
            end
        end

        // Response cycle; the ack here is stray and must be ignored.
        req_valid  = NP'($urandom);
        pipe_clear = 1'($urandom);
        priv_ack   = 1'b1;
        priv_rdata = $urandom;
        #1;
        exp_resp = '0;
        if (!dropped) exp_resp[g] = 1'b1;
        check_eq("resp_valid", 64'(resp_valid), 64'(exp_resp));
        check_eq("resp_rdata", 64'(resp_rdata), timed_out ? 64'd0 : 64'(rdata));
        check_eq("resp_err", 64'(resp_err), 64'(timed_out | inv));
        check_eq("resp_priv_req", 64'(priv_req), 64'd0);
        check_eq("resp_req_ready", 64'(req_ready), 64'd0);
        rr = (g + 1) % int'(NP);
        @(posedge CLK);
        #1;
        priv_ack = 1'b0;
    endtask

    initial begin
        rand_reqs();
        drive_reqs();
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Port 0 set, same-cycle ack.
        rand_reqs();
        tx_op[0] = 2'd1; tx_addr[0] = 12'h300; tx_wdata[0] = 32'h8;
        txn(3'b001, 1'b0, 0, 1'b0, -1, -1, 32'h1800);

        // Ports 0 and 1 requesting continuously.
        for (int i = 0; i < 4; i++) begin
            rand_reqs();
            txn(3'b011, 1'b0, 0, 1'b0, -1, -1, $urandom);
        end

        // Delayed ack, then timeout, then flush in issue, flush in idle.
        rand_reqs();
        txn(3'b111, 1'b0, 5, 1'b0, -1, -1, $urandom);
        rand_reqs();
        txn(3'b100, 1'b0, TO + 5, 1'b0, -1, -1, $urandom);
        rand_reqs();
        txn(3'b010, 1'b0, 3, 1'b0, 1, -1, $urandom);
        rand_reqs();
        txn(3'b011, 1'b1, 0, 1'b0, -1, -1, $urandom);

        // Invalid priv on a read-only access, then reset during issue.
        rand_reqs();
        tx_op[0] = 2'd3; tx_addr[0] = 12'hF14; tx_op[1] = 2'd3; tx_addr[1] = 12'hF14;
        tx_op[2] = 2'd3; tx_addr[2] = 12'hF14;
        txn(3'b111, 1'b0, 1, 1'b1, -1, -1, $urandom);
        rand_reqs();
        txn(3'b110, 1'b0, 5, 1'b0, -1, 2, $urandom);

        for (int t = 0; t < 300; t++) begin
            int delay;
            int clear_at;
            int rst_at;
            rand_reqs();
            delay    = ($urandom % 4 == 0) ? int'($urandom_range(0, TO + 3))
                                           : int'($urandom_range(0, 2));
            clear_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 4)) : -1;
            rst_at   = ($urandom % 25 == 0) ? int'($urandom_range(0, 3)) : -1;
            txn(NP'($urandom), ($urandom % 8) == 0, delay, ($urandom % 4) == 0,
                clear_at, rst_at, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
